// File: rtl/dt_pkg.sv
// Shared geometry, address widths and FSM encoding for the distance-map
// to binary-image repacker.
package dt_pkg;

    localparam int IMG_DIM   = 128;
    localparam int WORD_BITS = 16;
    localparam int WORDS     = 1024;

    localparam int ROW_W  = 7;
    localparam int GRP_W  = 3;
    localparam int BIT_W  = 4;
    localparam int RES_AW = ROW_W + GRP_W + BIT_W;
    localparam int STI_AW = ROW_W + GRP_W;
    localparam int CNT_W  = 15;

    localparam logic [CNT_W-1:0]  OBJ_MAX   = 15'h4000;
    localparam logic [STI_AW-1:0] LAST_WORD = 10'd1023;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/dt_bitpack.sv
// MSB-first 16-bit pixel packer with a saturating count of captured ones.
module dt_bitpack
    import dt_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 bit_in,
    output logic [WORD_BITS-1:0] word_next,
    output logic [CNT_W-1:0]     ones_cnt
);

    // Only 15 bits need storing: the 16th arrives on the cycle the word is taken.
    logic [WORD_BITS-2:0] sr_reg;
    logic [CNT_W-1:0]     ones_cnt_reg;

    assign word_next[0] = bit_in;

    genvar gi;
    generate
        for (gi = 1; gi < WORD_BITS; gi++) begin : g_shift
            assign word_next[gi] = sr_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            sr_reg       <= '0;
            ones_cnt_reg <= '0;
        end else if (en) begin
            sr_reg <= word_next[WORD_BITS-2:0];
            if (bit_in && (ones_cnt_reg != OBJ_MAX))
                ones_cnt_reg <= ones_cnt_reg + 15'd1;
        end
    end

    assign ones_cnt = ones_cnt_reg;

endmodule

// File: rtl/dt_repack.sv
// Walks the 128x128 distance RAM, thresholds each sample and writes packed
// 16-pixel words to the binary image RAM at a fixed 18 cycles per word.
module dt_repack
    import dt_pkg::*;
#(
    parameter logic [7:0] THR_DEF = 8'd1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 thr_sel,
    input  logic [7:0]           thr,
    output logic                 res_rd,
    output logic [RES_AW-1:0]    res_addr,
    input  logic [7:0]           res_di,
    output logic                 sti_wr,
    output logic [STI_AW-1:0]    sti_addr,
    output logic [WORD_BITS-1:0] sti_do,
    output logic [CNT_W-1:0]     obj_cnt,
    output logic                 busy,
    output logic                 done
);

    state_t               state_reg;
    logic [BIT_W-1:0]     k_reg;
    logic [STI_AW-1:0]    word_reg;
    logic [7:0]           thr_reg;
    logic                 rd_d1_reg;
    logic [STI_AW-1:0]    sti_addr_reg;
    logic [WORD_BITS-1:0] sti_do_reg;

    logic                 start_ok;
    logic                 pixel;
    logic [WORD_BITS-1:0] word_next;

    assign start_ok = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign pixel    = (res_di >= thr_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            k_reg        <= '0;
            word_reg     <= '0;
            thr_reg      <= THR_DEF;
            rd_d1_reg    <= 1'b0;
            sti_addr_reg <= '0;
            sti_do_reg   <= '0;
        end else begin
            // Read data returns one cycle after the strobe.
            rd_d1_reg <= (state_reg == ST_READ);
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state_reg <= ST_READ;
                        thr_reg   <= thr_sel ? thr : THR_DEF;
                        k_reg     <= '0;
                        word_reg  <= '0;
                    end
                end
                ST_READ: begin
                    k_reg <= k_reg + 4'd1;
                    if (k_reg == 4'd15)
                        state_reg <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    state_reg    <= ST_WRITE;
                    sti_addr_reg <= word_reg;
                    sti_do_reg   <= word_next;
                end
                ST_WRITE: begin
                    word_reg  <= word_reg + 10'd1;
                    state_reg <= (word_reg == LAST_WORD) ? ST_DONE : ST_READ;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    dt_bitpack u_bitpack (
        .clk       (clk),
        .reset     (reset),
        .clr       (start_ok),
        .en        (rd_d1_reg),
        .bit_in    (pixel),
        .word_next (word_next),
        .ones_cnt  (obj_cnt)
    );

    assign res_rd   = (state_reg == ST_READ);
    assign res_addr = {word_reg, k_reg};
    assign sti_wr   = (state_reg == ST_WRITE);
    assign sti_addr = sti_addr_reg;
    assign sti_do   = sti_do_reg;
    assign busy     = (state_reg == ST_READ) || (state_reg == ST_FLUSH) || (state_reg == ST_WRITE);
    assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_dt_repack.sv
// Scoreboard bench for dt_repack: a RAM model feeds distance samples, expected
// image words are queued at frame start and matched against every write.
module tb_dt_repack;
    import dt_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 thr_sel;
    logic [7:0]           thr;
    logic                 res_rd;
    logic [RES_AW-1:0]    res_addr;
    logic [7:0]           res_di;
    logic                 sti_wr;
    logic [STI_AW-1:0]    sti_addr;
    logic [WORD_BITS-1:0] sti_do;
    logic [CNT_W-1:0]     obj_cnt;
    logic                 busy;
    logic                 done;

    logic [7:0]  mem [IMG_DIM*IMG_DIM];
    logic [25:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_count = 0;
    int          exp_obj = 0;
    bit          mon_on = 1'b0;

    always #5 clk = ~clk;

    dt_repack #(.THR_DEF(8'd1)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .thr_sel  (thr_sel),
        .thr      (thr),
        .res_rd   (res_rd),
        .res_addr (res_addr),
        .res_di   (res_di),
        .sti_wr   (sti_wr),
        .sti_addr (sti_addr),
        .sti_do   (sti_do),
        .obj_cnt  (obj_cnt),
        .busy     (busy),
        .done     (done)
    );

    always @(posedge clk) begin
        if (res_rd)
            res_di <= mem[res_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Protocol monitor and scoreboard consumer.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("strobe_excl", {31'd0, res_rd & sti_wr}, 32'd0);
            chk("rd_in_busy", {31'd0, res_rd & ~busy}, 32'd0);
            if (sti_wr) begin
                logic [25:0] e;
                wr_count++;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sti_addr", {22'd0, sti_addr}, {22'd0, e[25:16]});
                    chk("sti_do", {16'd0, sti_do}, {16'd0, e[15:0]});
                end
            end
        end
    end

    task automatic build_expect(input logic [7:0] thr_eff);
        logic [15:0] w;
        exp_q.delete();
        exp_obj = 0;
        for (int a = 0; a < WORDS; a++) begin
            w = '0;
            for (int b = 0; b < WORD_BITS; b++) begin
                if (mem[(a / 8) * IMG_DIM + (a % 8) * 16 + b] >= thr_eff) begin
                    w[15-b] = 1'b1;
                    exp_obj++;
                end
            end
            exp_q.push_back({a[9:0], w});
        end
        if (exp_obj > 16384) exp_obj = 16384;
    endtask

    task automatic run_frame(input logic sel, input logic [7:0] t, input bit inject);
        int n;
        build_expect(sel ? t : 8'd1);
        wr_count = 0;
        @(negedge clk);
        start = 1'b1; thr_sel = sel; thr = t;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            // Starts during READ, FLUSH, WRITE and the final WRITE must be ignored.
            if (inject && (n == 17 || n == 18 || n == 100 || n == 18432)) begin
                start = 1'b1; thr_sel = 1'b1; thr = 8'd0;
            end else begin
                start = 1'b0;
            end
        end while (!done && n < 20000);
        start = 1'b0;
        chk("done_latency", n, 32'd18433);
        chk("write_count", wr_count, 32'd1024);
        chk("sb_leftover", exp_q.size(), 32'd0);
        chk("obj_cnt", {17'd0, obj_cnt}, exp_obj);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("done_held", {31'd0, done}, 32'd1);
        chk("no_strobe_in_done", {30'd0, res_rd, sti_wr}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; thr_sel = 1'b0; thr = 8'd0;
        for (int i = 0; i < IMG_DIM*IMG_DIM; i++) mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        start = 1'b1;                       // reset wins over start
        @(negedge clk);
        start = 1'b0;
        chk("rst_res_rd", {31'd0, res_rd}, 32'd0);
        chk("rst_sti_wr", {31'd0, sti_wr}, 32'd0);
        chk("rst_res_addr", {18'd0, res_addr}, 32'd0);
        chk("rst_sti_addr", {22'd0, sti_addr}, 32'd0);
        chk("rst_sti_do", {16'd0, sti_do}, 32'd0);
        chk("rst_obj_cnt", {17'd0, obj_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);

        // Ramp: res[r][c] = c, threshold 8, with stray starts mid-frame.
        for (int i = 0; i < IMG_DIM*IMG_DIM; i++) mem[i] = 8'(i % IMG_DIM);
        run_frame(1'b1, 8'd8, 1'b1);
        chk("ramp_obj_cnt", {17'd0, obj_cnt}, 32'd15360);

        // All 255 with threshold 0: every pixel set, count tops out exactly.
        for (int i = 0; i < IMG_DIM*IMG_DIM; i++) mem[i] = 8'd255;
        run_frame(1'b1, 8'd0, 1'b0);
        chk("full_obj_cnt", {17'd0, obj_cnt}, 32'd16384);

        // Single pixel at [5][17]; abort at cycle 500, then rerun cleanly.
        for (int i = 0; i < IMG_DIM*IMG_DIM; i++) mem[i] = 8'd0;
        mem[5*IMG_DIM + 17] = 8'd3;
        build_expect(8'd1);
        @(negedge clk);
        start = 1'b1; thr_sel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (499) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 40; c++) begin
            chk("abort_quiet", {28'd0, res_rd, sti_wr, busy, done}, 32'd0);
            chk("abort_obj_cnt", {17'd0, obj_cnt}, 32'd0);
            @(negedge clk);
        end
        run_frame(1'b0, 8'd0, 1'b0);
        chk("pix_obj_cnt", {17'd0, obj_cnt}, 32'd1);
        chk("pix_last_addr", {22'd0, sti_addr}, 32'd1023);

        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dt_repack.md
DT_REPACK -- requirements
Module: dt_repack

Interface
REQ-001 Parameter THR_DEF, default 8'd1, threshold used when thr_sel=0.
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse that begins a frame conversion; ignored unless the FSM is in IDLE or DONE.
REQ-005 thr_sel  in  1  0 = use THR_DEF, 1 = use thr; sampled on the start cycle.
REQ-006 thr  in  8  runtime threshold; sampled on the start cycle.
REQ-007 res_rd  out  1  read strobe to the 16384x8 distance RAM.
REQ-008 res_addr  out  14  distance RAM address {row[6:0], col[6:0]}.
REQ-009 res_di  in  8  distance RAM read data, valid exactly 1 cycle after the res_rd cycle.
REQ-010 sti_wr  out  1  write strobe to the 1024x16 binary image RAM.
REQ-011 sti_addr  out  10  image word address {row[6:0], grp[2:0]}.
REQ-012 sti_do  out  16  packed pixels; bit 15 = column 16*grp, bit 0 = column 16*grp+15.
REQ-013 obj_cnt  out  15  count of pixels written as 1 in the current frame.
REQ-014 busy  out  1  high from the cycle after accepted start until DONE entry.
REQ-015 done  out  1  high in DONE; held until the next accepted start or reset.

Function
REQ-016 The block converts a 128x128 distance map back to a packed binary image: pixel = 1 iff res_di >= threshold (unsigned 8-bit compare); threshold 0 forces all ones.
REQ-017 States: IDLE, READ, FLUSH, WRITE, DONE; the start pulse moves IDLE->READ or DONE->READ, latches the threshold, clears obj_cnt, drops done and zeroes row/grp/col counters.
REQ-018 READ lasts 16 cycles per word; in cycle k (k=0..15) res_rd=1 and res_addr={row, grp*16+k}.
REQ-019 Each returned bit shifts into a 16-bit register MSB-first, so the column-16*grp pixel ends up in bit 15.
REQ-020 FLUSH (1 cycle): res_rd=0; capture the 16th returned bit.
REQ-021 WRITE (1 cycle): sti_wr=1, sti_addr={row,grp}, sti_do=packed word; then increment grp (wrapping into row) and go to READ, or to DONE after word 1023.
REQ-022 Fixed cost: 18 cycles per word, 18432 cycles from the start cycle to the last WRITE; done rises on the following cycle.
REQ-023 obj_cnt increments by 1 per captured 1-bit and saturates at 16384 (15'h4000); max is exact, no wrap.
REQ-024 Outside READ, res_rd=0; outside WRITE, sti_wr=0 and sti_do/sti_addr hold their last values.
REQ-025 A start during READ/FLUSH/WRITE is ignored and has no side effects.
REQ-026 A start in the same cycle as the final WRITE is ignored; DONE is still entered.
REQ-027 The block never reads and writes in the same cycle.

Reset
REQ-028 When reset=1 at a clock edge: state=IDLE; res_rd=0, sti_wr=0, res_addr=0, sti_addr=0, sti_do=0, obj_cnt=0, busy=0, done=0; latched threshold=THR_DEF.
REQ-029 Reset asserted mid-frame aborts at once with no further strobes; a partially packed word is discarded.
REQ-030 Reset has priority over start in the same cycle.

Structure
REQ-031 Package dt_pkg holds IMG_DIM=128, WORD_BITS=16, WORDS=1024, the state enum and address-width constants; the DT block imports the same package.
REQ-032 One sub-module, dt_bitpack, holds the 16-bit MSB-first shift register and the ones counter; the FSM and address generation live in dt_repack.

Verification
REQ-033 All res=0, thr_sel=0 -> 1024 writes, every sti_do=16'h0000, obj_cnt=0, done at start+18433.
REQ-034 res[r][c]=c, thr_sel=1, thr=8'd8 -> grp0 words=16'h00FF, grp1..7 words=16'hFFFF; obj_cnt=128*120=15360.
REQ-035 Only res[5][17]=3, rest 0, THR_DEF=1 -> only sti_addr {5,1} = 16'h4000; obj_cnt=1.
REQ-036 All res=255, thr=0 -> all words 16'hFFFF; obj_cnt=16384 (saturated, not wrapped).
REQ-037 Reset at cycle 500, then start -> no strobes after reset; second frame output identical to a clean run; start pulses injected mid-frame change nothing.
REQ-038 Protocol monitor over all runs: res_rd only in READ, sti_wr exactly 1024 single-cycle pulses per frame, never both strobes in one cycle.
